crc_checker: RTL and testbench

- Receive-side counterpart of the serial CRC-8 generator.
- Accepts a serial frame of DATA_BITS payload bits followed by 8 CRC bits (LSB-first, as the generator emits them).
- Recomputes the CRC with the same seed and taps, compares it bit-by-bit against the received CRC, and reports pass/fail with a one-cycle DONE pulse.
- Sits at the receive end of the serial link, feeding frame-status logic.

---
 rtl/crc_pkg.sv | 28 ++
 rtl/crc8_lfsr.sv | 30 +++
 rtl/crc_checker.sv | 124 ++++++++++++
 tb/tb_crc_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC-8 constants, FSM state type and the single-bit LFSR step used by the
// serial CRC checker and generator.
package crc_pkg;

   localparam logic [7:0] CRC_SEED  = 8'hD8;
   localparam logic [7:0] CRC_TAPS  = 8'b01000100;
   localparam int         CRC_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } crc_state_t;

   // Feedback enters bit 7; each tap bit j XORs the feedback into bit j.
   function automatic logic [7:0] crc_step(input logic [7:0] lfsr, input logic d,
                                           input logic [7:0] taps = CRC_TAPS);
      logic       fb;
      logic [7:0] nxt;
      fb     = lfsr[0] ^ d;
      nxt[7] = fb;
      for (int unsigned j = 0; j < 7; j++) begin
         nxt[j] = lfsr[j+1] ^ (taps[j] & fb);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// CRC-8 LFSR register: seeded step at frame start, plain step during payload,
// zero-fill right shift while the CRC bits are compared.
module crc8_lfsr
   import crc_pkg::*;
#(
   parameter logic [7:0] SEED = CRC_SEED,
   parameter logic [7:0] TAPS = CRC_TAPS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       seed_step,
   input  logic       step,
   input  logic       shift,
   input  logic       d,
   output logic [7:0] lfsr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (seed_step) begin
         lfsr <= crc_step(SEED, d, TAPS);
      end else if (step) begin
         lfsr <= crc_step(lfsr, d, TAPS);
      end else if (shift) begin
         lfsr <= {1'b0, lfsr[7:1]};
      end
   end

endmodule

// File: rtl/crc_checker.sv
// Serial CRC-8 frame checker: DATA_BITS payload bits then 8 CRC bits LSB-first.
// Optional saturating error counter on port ERR_CNT when CRC_ERR_CNT_EN is defined.
module crc_checker
   import crc_pkg::*;
#(
   parameter int         DATA_BITS = 8,
   parameter logic [7:0] SEED      = CRC_SEED,
   parameter logic [7:0] TAPS      = CRC_TAPS
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       DATA,
   input  logic       ACTIVE,
   output logic       BUSY,
   output logic       DONE,
   output logic       CRC_OK,
   output logic       CRC_ERR
`ifdef CRC_ERR_CNT_EN
   ,
   output logic [7:0] ERR_CNT
`endif
);

   localparam int CNT_W = $clog2(((DATA_BITS > CRC_WIDTH) ? DATA_BITS : CRC_WIDTH) + 1);
   localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(CRC_WIDTH - 1);

   crc_state_t       state, state_nxt;
   logic [CNT_W-1:0] cntr, cntr_nxt;
   logic             mismatch, mismatch_nxt;
   logic             fin, cur, seed_step, step, shift;
   logic [7:0]       lfsr;

   crc8_lfsr #(.SEED(SEED), .TAPS(TAPS)) u_lfsr (
      .clk       (CLK),
      .rst       (RST),
      .seed_step (seed_step),
      .step      (step),
      .shift     (shift),
      .d         (DATA),
      .lfsr      (lfsr)
   );

   always_comb begin
      state_nxt    = state;
      cntr_nxt     = cntr;
      mismatch_nxt = mismatch;
      fin          = 1'b0;
      seed_step    = 1'b0;
      step         = 1'b0;
      shift        = 1'b0;
      cur          = DATA ^ lfsr[0];
      if (ACTIVE) begin
         case (state)
            IDLE: begin
               seed_step    = 1'b1;
               mismatch_nxt = 1'b0;
               if (DATA_BITS == 1) begin
                  state_nxt = CHECK;
                  cntr_nxt  = '0;
               end else begin
                  state_nxt = PAYLOAD;
                  cntr_nxt  = CNT_W'(1);
               end
            end
            PAYLOAD: begin
               step = 1'b1;
               if (cntr == LAST_PAY) begin
                  state_nxt = CHECK;
                  cntr_nxt  = '0;
               end else begin
                  cntr_nxt = cntr + CNT_W'(1);
               end
            end
            CHECK: begin
               shift        = 1'b1;
               mismatch_nxt = mismatch | cur;
               if (cntr == LAST_CRC) begin
                  state_nxt = IDLE;
                  cntr_nxt  = '0;
                  fin       = 1'b1;
               end else begin
                  cntr_nxt = cntr + CNT_W'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // The verdict folds in the final CRC bit, which is not yet part of mismatch.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         cntr     <= '0;
         mismatch <= 1'b0;
         DONE     <= 1'b0;
         CRC_OK   <= 1'b0;
         CRC_ERR  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cntr     <= cntr_nxt;
         mismatch <= mismatch_nxt;
         DONE     <= fin;
         if (fin) begin
            CRC_OK  <= ~(mismatch | cur);
            CRC_ERR <= mismatch | cur;
         end
      end
   end

   assign BUSY = (state != IDLE);

`ifdef CRC_ERR_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         ERR_CNT <= '0;
      end else if (fin && (mismatch | cur) && (ERR_CNT != '1)) begin
         ERR_CNT <= ERR_CNT + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_crc_checker.sv
// Self-checking bench for crc_checker: directed frames plus randomized frames
// with random gaps, against a frame-level CRC reference model.
module tb_crc_checker;

   localparam int         N      = 8;
   localparam logic [7:0] SEED_V = 8'hD8;
   localparam logic [7:0] TAPS_V = 8'b01000100;

   logic CLK = 1'b0;
   logic RST, DATA, ACTIVE;
   logic BUSY, DONE, CRC_OK, CRC_ERR;
`ifdef CRC_ERR_CNT_EN
   logic [7:0] ERR_CNT;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int bits_in     = 0;
   bit m_ok        = 1'b0;
   bit m_err       = 1'b0;
   bit pend_ok     = 1'b0;
   int m_errcnt    = 0;
   int done_cyc    = -1;

   always #5 CLK = ~CLK;

   crc_checker #(.DATA_BITS(N), .SEED(SEED_V), .TAPS(TAPS_V)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .DATA    (DATA),
      .ACTIVE  (ACTIVE),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .CRC_OK  (CRC_OK),
      .CRC_ERR (CRC_ERR)
`ifdef CRC_ERR_CNT_EN
      ,
      .ERR_CNT (ERR_CNT)
`endif
   );

   // Reference CRC: shift the register right, inject feedback into bit 7 and the taps.
   function automatic logic [7:0] ref_crc(input logic [N-1:0] pl);
      logic [7:0] r;
      logic       fb;
      r = SEED_V;
      for (int i = 0; i < N; i++) begin
         fb = r[0] ^ pl[i];
         r  = (r >> 1) ^ (fb ? {1'b1, TAPS_V[6:0]} : 8'h00);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic check_outputs(input bit exp_done);
      check("done", {31'd0, DONE}, {31'd0, exp_done});
      check("busy", {31'd0, BUSY}, {31'd0, bits_in != 0});
      check("crc_ok", {31'd0, CRC_OK}, {31'd0, m_ok});
      check("crc_err", {31'd0, CRC_ERR}, {31'd0, m_err});
`ifdef CRC_ERR_CNT_EN
      check("err_cnt", {24'd0, ERR_CNT}, m_errcnt);
`endif
   endtask

   task automatic idle(input int n);
      ACTIVE = 1'b0;
      DATA   = 1'($urandom);
      repeat (n) begin
         tick();
         check_outputs(1'b0);
      end
   endtask

   task automatic send_bit(input bit b);
      ACTIVE = 1'b1;
      DATA   = b;
      tick();
      bits_in++;
      if (bits_in == N + 8) begin
         bits_in  = 0;
         m_ok     = pend_ok;
         m_err    = !pend_ok;
         if (!pend_ok && m_errcnt < 255) m_errcnt++;
         done_cyc = cyc;
         check_outputs(1'b1);
      end else begin
         check_outputs(1'b0);
      end
   endtask

   task automatic send_frame(input logic [N-1:0] pl, input logic [7:0] crc,
                             input int gpos1, input int glen1,
                             input int gpos2, input int glen2,
                             input bit rgaps, input int nbits, output int start);
      logic [N+7:0] fr;
      int           g;
      fr      = {crc, pl};
      pend_ok = (crc == ref_crc(pl));
      start   = cyc;
      for (int i = 0; i < nbits; i++) begin
         g = 0;
         if (i == gpos1) g += glen1;
         if (i == gpos2) g += glen2;
         if (rgaps && i > 0 && $urandom_range(3) == 0) g += int'($urandom_range(3, 1));
         if (g > 0) idle(g);
         if (i == 0) start = cyc;
         send_bit(fr[i]);
      end
   endtask

   task automatic do_reset();
      RST    = 1'b1;
      ACTIVE = 1'b1;
      DATA   = 1'b1;
      tick();
      bits_in  = 0;
      m_ok     = 1'b0;
      m_err    = 1'b0;
      m_errcnt = 0;
      check_outputs(1'b0);
      RST    = 1'b0;
      ACTIVE = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          s;
      int          d1;
      logic [N-1:0] pl;
      logic [7:0]  crc;
      RST    = 1'b1;
      ACTIVE = 1'b0;
      DATA   = 1'b0;
      tick();
      tick();
      check_outputs(1'b0);
      RST = 1'b0;
      idle(2);

      // Good all-zero frame, continuous strobe
      send_frame('0, 8'h14, -1, 0, -1, 0, 1'b0, N + 8, s);
      check("lat_cont", done_cyc - s, 16);
      idle(3);

      // CRC bit 3 flipped
      send_frame('0, 8'h1C, -1, 0, -1, 0, 1'b0, N + 8, s);
      idle(2);

      // Gaps: 3 cycles after payload bit 5, 2 cycles mid-CRC
      send_frame('0, 8'h14, 5, 3, 12, 2, 1'b0, N + 8, s);
      check("lat_gaps", done_cyc - s, 21);

      // Back-to-back good frames
      send_frame('0, 8'h14, -1, 0, -1, 0, 1'b0, N + 8, s);
      d1 = done_cyc;
      send_frame('0, 8'h14, -1, 0, -1, 0, 1'b0, N + 8, s);
      check("b2b_spacing", done_cyc - d1, 16);
      idle(2);

      // Abort after 4 payload bits, then a fresh good frame
      send_frame('0, 8'h14, -1, 0, -1, 0, 1'b0, 4, s);
      do_reset();
      idle(2);
      pl = N'($urandom);
      send_frame(pl, ref_crc(pl), -1, 0, -1, 0, 1'b0, N + 8, s);
      idle(1);

`ifdef CRC_ERR_CNT_EN
      do_reset();
      for (int k = 0; k < 257; k++) begin
         pl = N'($urandom);
         send_frame(pl, ref_crc(pl) ^ 8'h01, -1, 0, -1, 0, 1'b0, N + 8, s);
      end
      check("err_cnt_sat", {24'd0, ERR_CNT}, 32'hFF);
      pl = N'($urandom);
      send_frame(pl, ref_crc(pl), -1, 0, -1, 0, 1'b0, N + 8, s);
      check("err_cnt_hold", {24'd0, ERR_CNT}, 32'hFF);
      idle(2);
`endif

      // Randomized frames: random payload, good or corrupted CRC, random gaps
      for (int k = 0; k < 40; k++) begin
         pl  = N'($urandom);
         crc = ref_crc(pl);
         if ($urandom_range(1) == 0) crc ^= 8'($urandom_range(255, 1));
         if (k == 20) begin
            send_frame(pl, crc, -1, 0, -1, 0, 1'b1, int'($urandom_range(N + 7, 1)), s);
            do_reset();
         end else begin
            send_frame(pl, crc, -1, 0, -1, 0, 1'b1, N + 8, s);
         end
         idle(int'($urandom_range(2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
